// File: rtl/bus_tenure_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------------
// bus_tenure_arbiter : 4-master round-robin arbiter, tenure limit, dead cycle
// Revision 1.0
// ------------------------------------------------------------------------
module bus_tenure_arbiter #(
  parameter int HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m0_req_,
  input  logic       m1_req_,
  input  logic       m2_req_,
  input  logic       m3_req_,
  output logic       m0_grnt_,
  output logic       m1_grnt_,
  output logic       m2_grnt_,
  output logic       m3_grnt_,
  output logic [1:0] owner,
  output logic       busy,
  output logic       preempt
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_GRANT    = 2'd1,
    S_HANDOVER = 2'd2
  } state_t;

  state_t     state_q;
  logic [1:0] owner_q;
  logic [7:0] hold_cnt_q;
  logic [3:0] grnt_q;
  logic       busy_q;
  logic       preempt_q;

  logic [3:0] req;
  logic [1:0] pick_d;
  logic [1:0] probe;
  logic       found;
  logic       any_req;
  logic       others_req;

  assign req        = ~{m3_req_, m2_req_, m1_req_, m0_req_};
  assign any_req    = |req;
  assign others_req = |(req & ~(4'b0001 << owner_q));

  // Search starts just after the current/last owner, so the departing master
  // is considered last and wins only when nobody else is asking.
  always_comb begin
    pick_d = owner_q;
    probe  = owner_q;
    found  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      probe = owner_q + 2'(k);
      if (!found && req[probe]) begin
        pick_d = probe;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      owner_q    <= 2'd3;
      hold_cnt_q <= 8'd0;
      grnt_q     <= 4'hF;
      busy_q     <= 1'b0;
      preempt_q  <= 1'b0;
    end else begin
      preempt_q <= 1'b0;
      case (state_q)
        S_IDLE, S_HANDOVER: begin
          if (any_req) begin
            state_q    <= S_GRANT;
            owner_q    <= pick_d;
            hold_cnt_q <= 8'd0;
            grnt_q     <= ~(4'b0001 << pick_d);
            busy_q     <= 1'b1;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_GRANT: begin
          // A voluntary release takes precedence over a coincident preemption.
          if (!req[owner_q]) begin
            state_q <= S_HANDOVER;
            grnt_q  <= 4'hF;
            busy_q  <= 1'b0;
          end else if (hold_cnt_q == HOLD_LAST && others_req) begin
            state_q   <= S_HANDOVER;
            grnt_q    <= 4'hF;
            busy_q    <= 1'b0;
            preempt_q <= 1'b1;
          end else if (hold_cnt_q != HOLD_LAST) begin
            hold_cnt_q <= hold_cnt_q + 8'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          grnt_q  <= 4'hF;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign m0_grnt_ = grnt_q[0];
  assign m1_grnt_ = grnt_q[1];
  assign m2_grnt_ = grnt_q[2];
  assign m3_grnt_ = grnt_q[3];
  assign owner    = owner_q;
  assign busy     = busy_q;
  assign preempt  = preempt_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_tenure_arbiter.sv
`default_nettype none
// Scoreboard bench: two arbiters (HOLD_MAX 8 and 1) share stimulus; a
// tenure-based reference model queues the expected outputs per edge.
module tb_bus_tenure_arbiter;

  typedef struct packed {
    logic [3:0] grnt;
    logic [1:0] owner;
    logic       busy;
    logic       preempt;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req_n = 4'hF;

  logic [3:0] g8, g1;
  logic [1:0] o8, o1;
  logic       b8, b1, p8, p1;

  int checks = 0;
  int errors = 0;
  bit stim_done = 1'b0;

  exp_t q8[$];
  exp_t q1[$];

  int hold_max[2] = '{8, 1};
  int holder[2];
  int m_owner[2];
  int tenure[2];
  bit m_pre[2];

  always #5 clk = ~clk;

  bus_tenure_arbiter #(.HOLD_MAX(8)) dut8 (
    .clk(clk), .reset(reset),
    .m0_req_(req_n[0]), .m1_req_(req_n[1]), .m2_req_(req_n[2]), .m3_req_(req_n[3]),
    .m0_grnt_(g8[0]), .m1_grnt_(g8[1]), .m2_grnt_(g8[2]), .m3_grnt_(g8[3]),
    .owner(o8), .busy(b8), .preempt(p8)
  );

  bus_tenure_arbiter #(.HOLD_MAX(1)) dut1 (
    .clk(clk), .reset(reset),
    .m0_req_(req_n[0]), .m1_req_(req_n[1]), .m2_req_(req_n[2]), .m3_req_(req_n[3]),
    .m0_grnt_(g1[0]), .m1_grnt_(g1[1]), .m2_grnt_(g1[2]), .m3_grnt_(g1[3]),
    .owner(o1), .busy(b1), .preempt(p1)
  );

  // Reference: a master holds the bus for 'tenure' cycles; nobody holding means
  // the next edge hands the bus to the first requester after the last owner.
  function automatic int rr_pick(input int last, input logic [3:0] req);
    for (int k = 1; k <= 4; k++) begin
      if (req[(last + k) % 4]) return (last + k) % 4;
    end
    return last;
  endfunction

  task automatic model_step(input int i, input logic rst, input logic [3:0] req);
    exp_t e;
    m_pre[i] = 1'b0;
    if (rst) begin
      holder[i]  = -1;
      m_owner[i] = 3;
      tenure[i]  = 0;
    end else if (holder[i] < 0) begin
      if (req != 4'h0) begin
        m_owner[i] = rr_pick(m_owner[i], req);
        holder[i]  = m_owner[i];
        tenure[i]  = 1;
      end
    end else if (!req[holder[i]]) begin
      holder[i] = -1;
    end else if (tenure[i] >= hold_max[i] && (req & ~(4'b0001 << holder[i])) != 4'h0) begin
      holder[i] = -1;
      m_pre[i]  = 1'b1;
    end else begin
      tenure[i] = tenure[i] + 1;
    end
    e.grnt    = (holder[i] < 0) ? 4'hF : ~(4'b0001 << holder[i]);
    e.owner   = 2'(m_owner[i]);
    e.busy    = (holder[i] >= 0);
    e.preempt = m_pre[i];
    if (i == 0) q8.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic drive(input logic rst, input logic [3:0] rn);
    reset = rst;
    req_n = rn;
    model_step(0, rst, ~rn);
    model_step(1, rst, ~rn);
    @(negedge clk);
  endtask

  task automatic cmp(input string name, input exp_t e, input logic [3:0] g,
                     input logic [1:0] o, input logic b, input logic p);
    checks += 4;
    if (g !== e.grnt) begin
      errors++;
      $display("FAIL %s grnt_ t=%0t got %b expected %b", name, $time, g, e.grnt);
    end
    if (o !== e.owner) begin
      errors++;
      $display("FAIL %s owner t=%0t got %0d expected %0d", name, $time, o, e.owner);
    end
    if (b !== e.busy) begin
      errors++;
      $display("FAIL %s busy t=%0t got %b expected %b", name, $time, b, e.busy);
    end
    if (p !== e.preempt) begin
      errors++;
      $display("FAIL %s preempt t=%0t got %b expected %b", name, $time, p, e.preempt);
    end
  endtask

  // Monitor: every edge the DUTs present a new registered output set.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q8.size() > 0) begin
        e = q8.pop_front();
        cmp("hold8", e, g8, o8, b8, p8);
      end else if (!stim_done) begin
        checks++; errors++;
        $display("FAIL hold8 scoreboard empty t=%0t got none expected entry", $time);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        cmp("hold1", e, g1, o1, b1, p1);
      end else if (!stim_done) begin
        checks++; errors++;
        $display("FAIL hold1 scoreboard empty t=%0t got none expected entry", $time);
      end
    end
  end

  initial begin
    logic [3:0] rn;
    // reset with m0 already requesting, then m0 alone (no contention)
    repeat (3) drive(1'b1, 4'b1110);
    repeat (22) drive(1'b0, 4'b1110);
    repeat (2) drive(1'b0, 4'b1111);
    // m0 and m2 contend continuously
    repeat (40) drive(1'b0, 4'b1010);
    // m1 owns, others join, m1 releases, then m2, m3 release in turn
    repeat (3) drive(1'b1, 4'b1111);
    repeat (2) drive(1'b0, 4'b1101);
    repeat (3) drive(1'b0, 4'b0000);
    repeat (3) drive(1'b0, 4'b0010);
    repeat (3) drive(1'b0, 4'b0110);
    repeat (3) drive(1'b0, 4'b1110);
    repeat (2) drive(1'b0, 4'b1111);
    // owner releases exactly when its tenure expires while m1 requests
    repeat (8) drive(1'b0, 4'b1110);
    repeat (3) drive(1'b0, 4'b1101);
    repeat (2) drive(1'b0, 4'b1111);
    // reset while m3 holds the bus, then m0 and m3 race
    repeat (3) drive(1'b0, 4'b0111);
    repeat (2) drive(1'b1, 4'b0111);
    repeat (4) drive(1'b0, 4'b0110);
    // all four masters request continuously
    repeat (20) drive(1'b0, 4'b0000);
    // random sticky requests with occasional reset
    rn = 4'hF;
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(5, 0) == 0) rn[b] = ~rn[b];
      end
      drive(($urandom_range(79, 0) == 0), rn);
    end
    drive(1'b0, 4'hF);
    stim_done = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    if (q8.size() != 0 || q1.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain got %0d/%0d left expected 0/0", q8.size(), q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bus_tenure_arbiter.md
# bus_tenure_arbiter

Round-robin bus arbiter for four bus masters that limits how long one master may hold the bus. A master that holds the grant for HOLD_MAX cycles while another master is requesting is preempted. Every change of ownership passes through one dead cycle with no grant asserted, so two masters never drive the bus in overlapping cycles. It sits between the masters' request/grant pins and the shared bus mux, and supplies the mux select through `owner`.

## Interface
- HOLD_MAX, default 8: maximum consecutive grant cycles before forced handover; legal range 1..255.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- m0_req_ .. m3_req_  in  1 each  bus request, active-low.
- m0_grnt_ .. m3_grnt_  out  1 each  bus grant, active-low, registered.
- owner  out  2  index of current or last granted master, registered.
- busy  out  1  high while any grant is asserted.
- preempt  out  1  one-cycle pulse when a forced handover occurs.

## Operation
- Reset values: all grnt_ = 1, owner = 2'd3, busy = 0, preempt = 0, state = IDLE, hold_cnt = 0.
- owner = 3 after reset means master 0 has top priority on the first arbitration.
- Round-robin pick: search from (owner+1) mod 4 upward with wrap, and take the first master with req_ = 0.
- State IDLE (no grant):
  - any req_ low at the edge -> GRANT to the picked master.
  - owner is updated to that master, hold_cnt = 0.
- State GRANT (only grnt_[owner] = 0, busy = 1):
  - owner req_ high at the edge -> HANDOVER. This is a normal release; preempt stays 0.
  - else if hold_cnt == HOLD_MAX-1 and some other req_ is low -> HANDOVER, with preempt = 1 for the next cycle.
  - else stay in GRANT; hold_cnt increments and saturates at HOLD_MAX-1.
  - At saturation with no other requester, the owner keeps the bus indefinitely, and the preempt condition is re-evaluated on every edge.
- State HANDOVER (all grnt_ = 1, busy = 0), lasts exactly one cycle:
  - any req_ low -> GRANT to the picked master, with hold_cnt = 0.
  - The search starts from the departing owner+1, so the departing master gets the lowest priority.
  - It can win only if it is the sole requester.
  - no request -> IDLE.
- Simultaneous events:
  - Owner release and the preempt condition on the same edge are treated as a normal release; preempt = 0.
  - Other masters' requests that appear or vanish during HANDOVER are sampled at the HANDOVER edge only.
- Reset mid-operation: at the reset edge all grants deassert and everything returns to reset values. No dead cycle is added beyond the reset itself.
- HOLD_MAX = 1: each owner gets exactly one grant cycle whenever another master is requesting.
- hold_cnt width is 8 bits internally, regardless of HOLD_MAX.

## Timing
- Request-to-grant from IDLE:
  - req_ falls before edge k; grnt_ low from edge k.
  - Latency is 1 cycle.
- Release-to-next-grant:
  - owner req_ rises before edge k; its grnt_ rises at edge k (HANDOVER).
  - the new grnt_ falls at edge k+1.
  - This gives exactly one dead cycle.
- Tenure under contention:
  - grant first low at edge g; forced HANDOVER at edge g+HOLD_MAX.
  - The grant is therefore low for exactly HOLD_MAX cycles.
- preempt: high for the single cycle following edge g+HOLD_MAX.
- owner and the grant outputs change on the same edge; owner is stable throughout HANDOVER.
- Outputs are fully registered: no combinational path from req_ to grnt_.

## Test plan
- Reset, then m0_req_ = 0 only:
  - grants stay deasserted during reset.
  - m0_grnt_ = 0 one cycle after the request, owner = 0.
  - m0_grnt_ stays low for 20 cycles with no preempt, since there is no contention.
- HOLD_MAX = 8, m0 and m2 both request continuously from IDLE:
  - m0 gets 8 cycles, then 1 dead cycle with preempt = 1, then m2 gets 8 cycles, then dead, then m0.
  - This pattern repeats with a period of 18 cycles.
- m1 owns the bus; m1_req_ rises while m0, m2 and m3 are requesting:
  - next grant goes to m2.
  - after m2 releases, m3; then m0.
- Owner releases on the same edge as hold_cnt == HOLD_MAX-1 with another master requesting:
  - HANDOVER is entered with preempt = 0.
- reset asserted while m3 is granted:
  - m3_grnt_ = 1 at the reset edge, owner = 3.
  - after reset deasserts, m0 and m3 both request; m0 wins first.
- HOLD_MAX = 1, all four masters request continuously:
  - grant order 0,1,2,3,0…, each for 1 cycle.
  - each grant is separated by a dead cycle, and preempt pulses in every dead cycle.
